// File: rtl/foxtrot_pkg.sv
// -----------------------------------------------------------------------------
// foxtrot_pkg
// Shared types and default widths for the foxtrot back end.
//   iq_entry_t  : one issue-queue entry (instruction fields plus per-operand
//                 source readiness and destination PRNs)
//   srcs_ready  : true when every used source of an entry is ready
// Widths (INST_ID_BITS, PRN_BITS, MAX_OPERANDS) are fixed here because the
// entry struct is shared by every block that stores or forwards instructions.
// -----------------------------------------------------------------------------
package foxtrot_pkg;

    localparam int INST_ID_BITS   = 6;
    localparam int PRN_BITS       = 6;
    localparam int MAX_OPERANDS   = 3;
    localparam int DEF_QUEUE_SIZE = 4;
    localparam int DEF_FU_COUNT   = 4;

    typedef struct packed {
        logic                                   valid;
        logic [INST_ID_BITS-1:0]                inst_id;
        logic [31:0]                            raw_instr;
        logic [63:0]                            pc;
        logic [MAX_OPERANDS-1:0]                prn_input_valid;
        logic [MAX_OPERANDS-1:0]                prn_input_ready;
        logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  prn_input;
        logic [MAX_OPERANDS-1:0]                prn_output_valid;
        logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  prn_output;
    } iq_entry_t;

    // A source counts as ready when it is unused or its ready bit is set.
    function automatic logic srcs_ready(input logic [MAX_OPERANDS-1:0] used,
                                        input logic [MAX_OPERANDS-1:0] rdy);
        return &(~used | rdy);
    endfunction

endpackage

// File: rtl/fu_issue_queue_if.sv
// -----------------------------------------------------------------------------
// fu_issue_queue_if
// Bundles the dispatch (router -> queue), wakeup, flush and issue
// (queue -> functional unit / register file) signals of fu_issue_queue.
//   slave  : the issue queue itself
//   master : the environment driving dispatch/wakeup and consuming issue
// -----------------------------------------------------------------------------
interface fu_issue_queue_if #(
    parameter int FU_COUNT = foxtrot_pkg::DEF_FU_COUNT
);
    import foxtrot_pkg::*;

    // dispatch side
    logic                                   in_inst_valid;
    logic [INST_ID_BITS-1:0]                in_inst_id;
    logic [31:0]                            in_raw_instr;
    logic [63:0]                            in_instr_pc;
    logic [MAX_OPERANDS-1:0]                in_prn_input_valid;
    logic [MAX_OPERANDS-1:0]                in_prn_input_ready;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  in_prn_input;
    logic [MAX_OPERANDS-1:0]                in_prn_output_valid;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  in_prn_output;
    logic                                   queue_ready;

    // wakeup broadcasts and flush
    logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]                wake_valid;
    logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0]  wake_prn;
    logic                                                 flush;

    // issue side
    logic                                   fu_ready;
    logic                                   issue_valid;
    logic [INST_ID_BITS-1:0]                issue_inst_id;
    logic [31:0]                            issue_raw_instr;
    logic [63:0]                            issue_instr_pc;
    logic [MAX_OPERANDS-1:0]                issue_prn_output_valid;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  issue_prn_output;
    logic [MAX_OPERANDS-1:0]                prf_read_enable;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  prf_read_prn;

    modport slave (
        input  in_inst_valid, in_inst_id, in_raw_instr, in_instr_pc,
               in_prn_input_valid, in_prn_input_ready, in_prn_input,
               in_prn_output_valid, in_prn_output,
               wake_valid, wake_prn, flush, fu_ready,
        output queue_ready, issue_valid, issue_inst_id, issue_raw_instr,
               issue_instr_pc, issue_prn_output_valid, issue_prn_output,
               prf_read_enable, prf_read_prn
    );

    modport master (
        output in_inst_valid, in_inst_id, in_raw_instr, in_instr_pc,
               in_prn_input_valid, in_prn_input_ready, in_prn_input,
               in_prn_output_valid, in_prn_output,
               wake_valid, wake_prn, flush, fu_ready,
        input  queue_ready, issue_valid, issue_inst_id, issue_raw_instr,
               issue_instr_pc, issue_prn_output_valid, issue_prn_output,
               prf_read_enable, prf_read_prn
    );

endinterface

// File: rtl/fu_issue_queue_chk.sv
// -----------------------------------------------------------------------------
// fu_issue_queue_chk
// Simulation-only observer for fu_issue_queue. Flags a dispatch attempted
// while the queue is full; the queue drops such an instruction by design.
//   clk, rst       : queue clock and active-low reset
//   i_inst_valid   : router presents an instruction
//   i_queue_ready  : queue has a free entry
// -----------------------------------------------------------------------------
module fu_issue_queue_chk (
    input logic clk,
    input logic rst,
    input logic i_inst_valid,
    input logic i_queue_ready
);

    // Report dispatches that arrive while no entry is free.
    always @(posedge clk) begin
        if (rst) begin
            assert (!(i_inst_valid && !i_queue_ready))
                else $warning("fu_issue_queue: dispatch while full, instruction dropped");
        end
    end

endmodule

// File: rtl/fu_issue_queue_sel.sv
// -----------------------------------------------------------------------------
// iq_oldest_ready_sel
// Fixed-priority picker for the collapsing issue queue: index 0 is the oldest
// entry, so the lowest set request bit wins.
//   i_ready : N-bit per-entry "all sources ready" vector
//   o_grant : one-hot grant (all zero when nothing is ready)
//   o_found : at least one entry is ready
// -----------------------------------------------------------------------------
module iq_oldest_ready_sel #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_ready,
    output logic [N-1:0] o_grant,
    output logic         o_found
);

    // Isolate the lowest set bit with x & -x.
    always_comb begin
        o_grant = i_ready & (~i_ready + N'(1));
        o_found = |i_ready;
    end

endmodule

// File: rtl/fu_issue_queue.sv
// -----------------------------------------------------------------------------
// fu_issue_queue
// Per-functional-unit reservation station. Accepts one routed instruction per
// cycle into a QUEUE_SIZE-entry collapsing, age-ordered buffer (index 0 is
// oldest), tracks source readiness from the wakeup broadcasts of all FUs,
// moves the oldest fully-ready entry into a registered issue slot and holds it
// until the FU accepts.
//   clk        : rising-edge clock
//   rst        : asynchronous active-low reset
//   iq (slave) : dispatch, queue_ready, wakeup, flush, fu_ready, issue and
//                PRF read signals (see fu_issue_queue_if)
// Optional feature macro: FU_ISSUE_QUEUE_WAKEUP_BYPASS_EN
//   defined   : select also honours same-cycle wakeups (one cycle faster)
//   undefined : select uses stored ready bits only (shorter timing path)
// -----------------------------------------------------------------------------
module fu_issue_queue #(
    parameter int QUEUE_SIZE = foxtrot_pkg::DEF_QUEUE_SIZE,
    parameter int FU_COUNT   = foxtrot_pkg::DEF_FU_COUNT
) (
    input logic             clk,
    input logic             rst,
    fu_issue_queue_if.slave iq
);
    import foxtrot_pkg::*;

    localparam int                CNT_W    = $clog2(QUEUE_SIZE + 1);
    localparam int                IDX_W    = $clog2(QUEUE_SIZE);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(QUEUE_SIZE);

    typedef logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]                wv_t;
    typedef logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0]  wp_t;

    iq_entry_t          r_entries [QUEUE_SIZE];
    iq_entry_t          r_slot;
    logic [CNT_W-1:0]   r_count;

    iq_entry_t          w_woken       [QUEUE_SIZE];
    iq_entry_t          w_shift       [QUEUE_SIZE];
    iq_entry_t          w_entries_nxt [QUEUE_SIZE];
    iq_entry_t          w_new_raw;
    iq_entry_t          w_new_entry;
    iq_entry_t          w_slot_nxt;
    logic [QUEUE_SIZE-1:0] w_elig;
    logic [QUEUE_SIZE-1:0] w_grant;
    logic               w_found;
    logic               w_sel_en;
    logic               w_take;
    logic               w_full;
    logic               w_enq;
    logic [IDX_W-1:0]   w_sel_idx;
    logic [CNT_W-1:0]   w_enq_pos;
    logic [CNT_W-1:0]   w_count_nxt;

    // True when any asserted broadcast carries this PRN.
    function automatic logic wake_hit(input logic [PRN_BITS-1:0] prn,
                                      input wv_t wv, input wp_t wp);
        logic hit;
        hit = 1'b0;
        for (int f = 0; f < FU_COUNT; f++) begin
            for (int k = 0; k < MAX_OPERANDS; k++) begin
                hit = hit | (wv[f][k] & (wp[f][k] == prn));
            end
        end
        return hit;
    endfunction

    // Set the ready bit of every used source that matches a broadcast.
    function automatic iq_entry_t apply_wake(input iq_entry_t e, input wv_t wv, input wp_t wp);
        iq_entry_t r;
        r = e;
        for (int k = 0; k < MAX_OPERANDS; k++) begin
            r.prn_input_ready[k] = e.prn_input_ready[k]
                                 | (e.prn_input_valid[k] & wake_hit(e.prn_input[k], wv, wp));
        end
        return r;
    endfunction

    // Fold this cycle's wakeups into resident entries and decide select eligibility.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            w_woken[i] = apply_wake(r_entries[i], iq.wake_valid, iq.wake_prn);
`ifdef FU_ISSUE_QUEUE_WAKEUP_BYPASS_EN
            w_elig[i]  = r_entries[i].valid
                       & srcs_ready(r_entries[i].prn_input_valid, w_woken[i].prn_input_ready);
`else
            w_elig[i]  = r_entries[i].valid
                       & srcs_ready(r_entries[i].prn_input_valid, r_entries[i].prn_input_ready);
`endif
        end
    end

    iq_oldest_ready_sel #(.N(QUEUE_SIZE)) u_sel (
        .i_ready (w_elig),
        .o_grant (w_grant),
        .o_found (w_found)
    );

    // Select/enqueue control and occupancy bookkeeping.
    always_comb begin
        w_sel_en  = ~r_slot.valid | iq.fu_ready;
        w_take    = w_found & w_sel_en;
        w_sel_idx = '0;
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            w_sel_idx = w_sel_idx | ({IDX_W{w_grant[i]}} & IDX_W'(i));
        end
        w_full      = (r_count == FULL_CNT);
        w_enq       = iq.in_inst_valid & ~w_full & ~iq.flush;
        // When an entry leaves, the tail moves down one, so the new entry lands one lower.
        w_enq_pos   = w_take ? (r_count - CNT_W'(1)) : r_count;
        w_count_nxt = r_count + CNT_W'(w_enq) - CNT_W'(w_take);
    end

    // Build the incoming entry; same-cycle wakeups apply to it too.
    always_comb begin
        w_new_raw                  = '0;
        w_new_raw.valid            = 1'b1;
        w_new_raw.inst_id          = iq.in_inst_id;
        w_new_raw.raw_instr        = iq.in_raw_instr;
        w_new_raw.pc               = iq.in_instr_pc;
        w_new_raw.prn_input_valid  = iq.in_prn_input_valid;
        w_new_raw.prn_input_ready  = iq.in_prn_input_ready;
        w_new_raw.prn_input        = iq.in_prn_input;
        w_new_raw.prn_output_valid = iq.in_prn_output_valid;
        w_new_raw.prn_output       = iq.in_prn_output;
        w_new_entry                = apply_wake(w_new_raw, iq.wake_valid, iq.wake_prn);
    end

    // Collapse above the selected entry and insert the new one at the tail.
    always_comb begin
        for (int j = 0; j < QUEUE_SIZE - 1; j++) begin
            w_shift[j] = w_woken[j + 1];
        end
        w_shift[QUEUE_SIZE-1] = '0;
        for (int j = 0; j < QUEUE_SIZE; j++) begin
            w_entries_nxt[j] = (w_enq && (CNT_W'(j) == w_enq_pos)) ? w_new_entry :
                               (w_take && (j >= int'(w_sel_idx)))  ? w_shift[j]  :
                                                                     w_woken[j];
        end
    end

    // Issue slot: load on select, empty on accept, otherwise hold.
    always_comb begin
        if (w_take) begin
            w_slot_nxt = w_woken[w_sel_idx];
        end else if (iq.fu_ready) begin
            w_slot_nxt = '0;
        end else begin
            w_slot_nxt = r_slot;
        end
    end

    // State registers; flush clears everything and discards same-cycle enqueue/wakeup.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
            r_slot  <= '0;
            for (int i = 0; i < QUEUE_SIZE; i++) begin
                r_entries[i] <= '0;
            end
        end else if (iq.flush) begin
            r_count <= '0;
            r_slot  <= '0;
            for (int i = 0; i < QUEUE_SIZE; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            r_count   <= w_count_nxt;
            r_slot    <= w_slot_nxt;
            r_entries <= w_entries_nxt;
        end
    end

    // Outputs decode registered state only.
    assign iq.queue_ready            = ~w_full;
    assign iq.issue_valid            = r_slot.valid;
    assign iq.issue_inst_id          = r_slot.inst_id;
    assign iq.issue_raw_instr        = r_slot.raw_instr;
    assign iq.issue_instr_pc         = r_slot.pc;
    assign iq.issue_prn_output_valid = r_slot.prn_output_valid;
    assign iq.issue_prn_output       = r_slot.prn_output;
    assign iq.prf_read_enable        = {MAX_OPERANDS{r_slot.valid}} & r_slot.prn_input_valid;
    assign iq.prf_read_prn           = r_slot.prn_input;

    fu_issue_queue_chk u_chk (
        .clk           (clk),
        .rst           (rst),
        .i_inst_valid  (iq.in_inst_valid),
        .i_queue_ready (iq.queue_ready)
    );

endmodule

// File: tb/tb_fu_issue_queue.sv
// -----------------------------------------------------------------------------
// tb_fu_issue_queue
// Directed bench for fu_issue_queue: reset, dispatch, fill/overflow,
// oldest-ready priority, same-cycle wakeup, backpressure, flush and async reset.
// -----------------------------------------------------------------------------
module tb_fu_issue_queue;

`ifdef FU_ISSUE_QUEUE_WAKEUP_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;

    fu_issue_queue_if #(.FU_COUNT(4)) bus ();

    fu_issue_queue #(.QUEUE_SIZE(4), .FU_COUNT(4)) dut (
        .clk (clk),
        .rst (rst),
        .iq  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.in_inst_valid       = 1'b0;
        bus.in_inst_id          = '0;
        bus.in_raw_instr        = '0;
        bus.in_instr_pc         = '0;
        bus.in_prn_input_valid  = '0;
        bus.in_prn_input_ready  = '0;
        bus.in_prn_input        = '0;
        bus.in_prn_output_valid = '0;
        bus.in_prn_output       = '0;
        bus.wake_valid          = '0;
        bus.wake_prn            = '0;
        bus.flush               = 1'b0;
    endtask

    task automatic set_inst(input logic [5:0] id, input logic [2:0] sv, input logic [2:0] sr,
                            input logic [5:0] p0, input logic [5:0] p1, input logic [5:0] p2);
        bus.in_inst_valid       = 1'b1;
        bus.in_inst_id          = id;
        bus.in_raw_instr        = {16'hA5A5, 10'd0, id};
        bus.in_instr_pc         = 64'h0000_0000_8000_0000 + {56'd0, id, 2'b00};
        bus.in_prn_input_valid  = sv;
        bus.in_prn_input_ready  = sr;
        bus.in_prn_input[0]     = p0;
        bus.in_prn_input[1]     = p1;
        bus.in_prn_input[2]     = p2;
        bus.in_prn_output_valid = 3'b001;
        bus.in_prn_output       = '0;
        bus.in_prn_output[0]    = id;
    endtask

    task automatic set_wake(input logic [5:0] prn);
        bus.wake_valid[2][1] = 1'b1;
        bus.wake_prn[2][1]   = prn;
    endtask

    task automatic test_reset();
        clear_inputs();
        bus.fu_ready = 1'b1;
        rst = 1'b0;
        step();
        step();
        n_vec++; if (bus.issue_valid !== 1'b0) begin n_bad++; $display("FAIL rst_issue_valid: got %b exp 0", bus.issue_valid); end
        n_vec++; if (bus.queue_ready !== 1'b1) begin n_bad++; $display("FAIL rst_queue_ready: got %b exp 1", bus.queue_ready); end
        n_vec++; if (bus.prf_read_enable !== 3'b000) begin n_bad++; $display("FAIL rst_prf_en: got %b exp 000", bus.prf_read_enable); end
        n_vec++; if (bus.issue_inst_id !== 6'd0) begin n_bad++; $display("FAIL rst_inst_id: got %0d exp 0", bus.issue_inst_id); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_dispatch();
        bus.fu_ready = 1'b1;
        set_inst(6'd5, 3'b011, 3'b011, 6'd10, 6'd11, 6'd0);
        step();
        clear_inputs();
        n_vec++; if (bus.issue_valid !== 1'b0) begin n_bad++; $display("FAIL disp_n1_valid: got %b exp 0", bus.issue_valid); end
        step();
        n_vec++; if (bus.issue_valid !== 1'b1) begin n_bad++; $display("FAIL disp_n2_valid: got %b exp 1", bus.issue_valid); end
        n_vec++; if (bus.issue_inst_id !== 6'd5) begin n_bad++; $display("FAIL disp_id: got %0d exp 5", bus.issue_inst_id); end
        n_vec++; if (bus.prf_read_enable !== 3'b011) begin n_bad++; $display("FAIL disp_prf_en: got %b exp 011", bus.prf_read_enable); end
        n_vec++; if (bus.prf_read_prn[1] !== 6'd11) begin n_bad++; $display("FAIL disp_prf_prn1: got %0d exp 11", bus.prf_read_prn[1]); end
        n_vec++; if (bus.issue_instr_pc !== 64'h0000_0000_8000_0014) begin n_bad++; $display("FAIL disp_pc: got %h exp 80000014", bus.issue_instr_pc); end
        n_vec++; if (bus.issue_raw_instr !== 32'hA5A5_0005) begin n_bad++; $display("FAIL disp_raw: got %h exp a5a50005", bus.issue_raw_instr); end
        n_vec++; if (bus.issue_prn_output[0] !== 6'd5) begin n_bad++; $display("FAIL disp_dst: got %0d exp 5", bus.issue_prn_output[0]); end
        step();
        n_vec++; if (bus.issue_valid !== 1'b0) begin n_bad++; $display("FAIL disp_drain: got %b exp 0", bus.issue_valid); end
    endtask

    task automatic test_fill_overflow();
        bus.fu_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_inst(6'(i), 3'b001, 3'b000, 6'd9, 6'd0, 6'd0);
            step();
        end
        clear_inputs();
        n_vec++; if (bus.queue_ready !== 1'b0) begin n_bad++; $display("FAIL fill_full: got %b exp 0", bus.queue_ready); end
        n_vec++; if (bus.issue_valid !== 1'b0) begin n_bad++; $display("FAIL fill_no_issue: got %b exp 0", bus.issue_valid); end
        set_inst(6'd4, 3'b000, 3'b000, 6'd0, 6'd0, 6'd0);
        step();
        clear_inputs();
        n_vec++; if (bus.queue_ready !== 1'b0) begin n_bad++; $display("FAIL overflow_full: got %b exp 0", bus.queue_ready); end
        set_wake(6'd9);
        step();
        clear_inputs();
        n_vec++; if (bus.issue_valid !== BYPASS) begin n_bad++; $display("FAIL wake_latency: got %b exp %b", bus.issue_valid, BYPASS); end
        if (!BYPASS) step();
        for (int k = 0; k < 4; k++) begin
            n_vec++; if (bus.issue_valid !== 1'b1 || bus.issue_inst_id !== 6'(k)) begin
                n_bad++; $display("FAIL order_%0d: got valid %b id %0d exp valid 1 id %0d", k, bus.issue_valid, bus.issue_inst_id, k);
            end
            step();
        end
        n_vec++; if (bus.issue_valid !== 1'b0) begin n_bad++; $display("FAIL overflow_dropped: got valid %b id %0d exp 0", bus.issue_valid, bus.issue_inst_id); end
        n_vec++; if (bus.queue_ready !== 1'b1) begin n_bad++; $display("FAIL fill_empty: got %b exp 1", bus.queue_ready); end
    endtask

    task automatic test_oldest_ready();
        bus.fu_ready = 1'b1;
        set_inst(6'd10, 3'b001, 3'b000, 6'd3, 6'd0, 6'd0);
        step();
        set_inst(6'd11, 3'b001, 3'b001, 6'd20, 6'd0, 6'd0);
        step();
        clear_inputs();
        step();
        n_vec++; if (bus.issue_valid !== 1'b1 || bus.issue_inst_id !== 6'd11) begin n_bad++; $display("FAIL oldest_first: got valid %b id %0d exp 1/11", bus.issue_valid, bus.issue_inst_id); end
        set_wake(6'd3);
        step();
        clear_inputs();
        if (!BYPASS) begin
            n_vec++; if (bus.issue_valid !== 1'b0) begin n_bad++; $display("FAIL oldest_gap: got %b exp 0", bus.issue_valid); end
            step();
        end
        n_vec++; if (bus.issue_valid !== 1'b1 || bus.issue_inst_id !== 6'd10) begin n_bad++; $display("FAIL oldest_second: got valid %b id %0d exp 1/10", bus.issue_valid, bus.issue_inst_id); end
        step();
        n_vec++; if (bus.issue_valid !== 1'b0) begin n_bad++; $display("FAIL oldest_drain: got %b exp 0", bus.issue_valid); end
    endtask

    task automatic test_same_cycle_wake();
        bus.fu_ready = 1'b1;
        set_inst(6'd20, 3'b001, 3'b000, 6'd7, 6'd0, 6'd0);
        set_wake(6'd7);
        step();
        clear_inputs();
        step();
        n_vec++; if (bus.issue_valid !== 1'b1 || bus.issue_inst_id !== 6'd20) begin n_bad++; $display("FAIL enq_wake: got valid %b id %0d exp 1/20", bus.issue_valid, bus.issue_inst_id); end
        step();
        n_vec++; if (bus.issue_valid !== 1'b0) begin n_bad++; $display("FAIL enq_wake_drain: got %b exp 0", bus.issue_valid); end
    endtask

    task automatic test_backpressure();
        bus.fu_ready = 1'b0;
        set_inst(6'd30, 3'b111, 3'b111, 6'd1, 6'd2, 6'd3);
        step();
        set_inst(6'd31, 3'b101, 3'b101, 6'd4, 6'd5, 6'd6);
        step();
        clear_inputs();
        for (int c = 0; c < 3; c++) begin
            n_vec++; if (bus.issue_valid !== 1'b1 || bus.issue_inst_id !== 6'd30) begin n_bad++; $display("FAIL bp_hold_%0d: got valid %b id %0d exp 1/30", c, bus.issue_valid, bus.issue_inst_id); end
            n_vec++; if (bus.prf_read_prn[2] !== 6'd3 || bus.prf_read_prn[0] !== 6'd1) begin n_bad++; $display("FAIL bp_prn_%0d: got %0d/%0d exp 1/3", c, bus.prf_read_prn[0], bus.prf_read_prn[2]); end
            n_vec++; if (bus.prf_read_enable !== 3'b111) begin n_bad++; $display("FAIL bp_en_%0d: got %b exp 111", c, bus.prf_read_enable); end
            step();
        end
        bus.fu_ready = 1'b1;
        step();
        n_vec++; if (bus.issue_valid !== 1'b1 || bus.issue_inst_id !== 6'd31) begin n_bad++; $display("FAIL bp_next: got valid %b id %0d exp 1/31", bus.issue_valid, bus.issue_inst_id); end
        n_vec++; if (bus.prf_read_enable !== 3'b101) begin n_bad++; $display("FAIL bp_next_en: got %b exp 101", bus.prf_read_enable); end
        step();
        n_vec++; if (bus.issue_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain: got %b exp 0", bus.issue_valid); end
    endtask

    task automatic test_flush_and_reset();
        bus.fu_ready = 1'b0;
        set_inst(6'd40, 3'b001, 3'b001, 6'd1, 6'd0, 6'd0);
        step();
        for (int i = 41; i < 44; i++) begin
            set_inst(6'(i), 3'b001, 3'b000, 6'd50, 6'd0, 6'd0);
            step();
        end
        clear_inputs();
        n_vec++; if (bus.issue_valid !== 1'b1 || bus.issue_inst_id !== 6'd40) begin n_bad++; $display("FAIL pre_flush_slot: got valid %b id %0d exp 1/40", bus.issue_valid, bus.issue_inst_id); end
        set_inst(6'd44, 3'b000, 3'b000, 6'd0, 6'd0, 6'd0);
        set_wake(6'd50);
        bus.flush = 1'b1;
        step();
        clear_inputs();
        n_vec++; if (bus.issue_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %b exp 0", bus.issue_valid); end
        n_vec++; if (bus.queue_ready !== 1'b1) begin n_bad++; $display("FAIL flush_ready: got %b exp 1", bus.queue_ready); end
        n_vec++; if (bus.prf_read_enable !== 3'b000) begin n_bad++; $display("FAIL flush_prf_en: got %b exp 000", bus.prf_read_enable); end
        bus.fu_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_vec++; if (bus.issue_valid !== 1'b0) begin n_bad++; $display("FAIL flush_empty_%0d: got valid %b id %0d exp 0", c, bus.issue_valid, bus.issue_inst_id); end
        end
        bus.fu_ready = 1'b0;
        for (int i = 60; i < 63; i++) begin
            set_inst(6'(i), 3'b001, 3'b000, 6'd60, 6'd0, 6'd0);
            step();
        end
        clear_inputs();
        n_vec++; if (bus.queue_ready !== 1'b1) begin n_bad++; $display("FAIL flush_count: got %b exp 1", bus.queue_ready); end
        set_inst(6'd51, 3'b001, 3'b001, 6'd1, 6'd0, 6'd0);
        step();
        clear_inputs();
        n_vec++; if (bus.queue_ready !== 1'b0) begin n_bad++; $display("FAIL refill_full: got %b exp 0", bus.queue_ready); end
        step();
        n_vec++; if (bus.issue_valid !== 1'b1 || bus.issue_inst_id !== 6'd51) begin n_bad++; $display("FAIL skip_to_ready: got valid %b id %0d exp 1/51", bus.issue_valid, bus.issue_inst_id); end
        #2;
        rst = 1'b0;
        #1;
        n_vec++; if (bus.issue_valid !== 1'b0) begin n_bad++; $display("FAIL arst_valid: got %b exp 0", bus.issue_valid); end
        n_vec++; if (bus.queue_ready !== 1'b1) begin n_bad++; $display("FAIL arst_ready: got %b exp 1", bus.queue_ready); end
        n_vec++; if (bus.prf_read_enable !== 3'b000) begin n_bad++; $display("FAIL arst_prf_en: got %b exp 000", bus.prf_read_enable); end
        n_vec++; if (bus.issue_inst_id !== 6'd0 || bus.issue_instr_pc !== 64'd0) begin n_bad++; $display("FAIL arst_data: got id %0d pc %h exp 0/0", bus.issue_inst_id, bus.issue_instr_pc); end
        #2;
        rst = 1'b1;
        step();
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst   = 1'b0;
        test_reset();
        test_dispatch();
        test_fill_overflow();
        test_oldest_ready();
        test_same_cycle_wake();
        test_backpressure();
        test_flush_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
